// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-word reads to the instruction RAM,
// registers each returned word and hands it to decode over valid/ready.
// Handles branch redirect, halt-word / address-limit halt and a fetch counter.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]    PC_LIMIT  = ADDR_W'(16),
  parameter logic [DATA_W-1:0]    HALT_WORD = '1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] Branch_target,
  output logic              Enable_i,
  output logic              RW_ram_i,
  output logic [ADDR_W-1:0] Address_in_i,
  input  logic [DATA_W-1:0] Out_i,
  output logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] Instr_pc,
  output logic              Instr_valid,
  input  logic              Instr_ready,
  output logic              Halted,
  output logic [15:0]       Fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic [15:0]       count_q, count_d;

  // State and datapath registers; async active-low reset drops any in-flight fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: a branch is applied last so it overrides the normal
  // progression, while a same-cycle ISSUE transfer is still counted first.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    count_d = count_q;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
          count_d = '0;
        end
      end
      S_FETCH: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (Out_i == HALT_WORD) begin
          state_d = S_HALT;
        end else begin
          instr_d = Out_i;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (valid_q && Instr_ready) begin
          valid_d = 1'b0;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end
          state_d = (pc_q >= PC_LIMIT) ? S_HALT : S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (Branch_taken &&
        (state_q == S_FETCH || state_q == S_CAPTURE || state_q == S_ISSUE)) begin
      pc_d    = Branch_target;
      valid_d = 1'b0;
      state_d = (Branch_target < PC_LIMIT) ? S_FETCH : S_HALT;
    end
  end

  // The RAM address is registered on entry to FETCH so it is stable for the request.
  always_comb begin
    addr_d = addr_q;
    if (state_d == S_FETCH) begin
      addr_d = pc_d;
    end
  end

  assign Enable_i     = (state_q == S_FETCH);
  assign RW_ram_i     = 1'b1;
  assign Address_in_i = addr_q;
  assign Instruction  = instr_q;
  assign Instr_pc     = ipc_q;
  assign Instr_valid  = valid_q;
  assign Halted       = (state_q == S_HALT);
  assign Fetch_count  = count_q;

endmodule
